randomlogic_window_acc: RTL and testbench

- Downstream consumer of the randomlogic_1 `Out` stream. Samples the registered 8-bit result when qualified by a valid strobe.
- Accumulates fixed-length windows of WINDOW samples and reports sum, minimum and maximum per window.
- Results are presented through a one-entry valid/ready result register. The upstream stage has no backpressure, so the input never stalls; overrun is flagged rather than blocking.

---
 rtl/randomlogic_pkg.sv | 22 ++
 rtl/randomlogic_minmax.sv | 25 ++
 rtl/randomlogic_window_acc.sv | 125 ++++++++++++
 tb/tb_randomlogic_window_acc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/randomlogic_pkg.sv
// Shared definitions for the randomlogic blocks: default sample width,
// the sample type and the constant log2 helper used to size counters and sums.
package randomlogic_pkg;

    localparam int DW_DEFAULT = 8;

    typedef logic [DW_DEFAULT-1:0] sample_t;

    // Ceiling log2, usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/randomlogic_minmax.sv
// Combinational unsigned min or max of two operands; pick_max selects which
// of the two the instance produces.
module randomlogic_minmax
    import randomlogic_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          pick_max,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    logic a_lt_b;

    always_comb begin
        a_lt_b = (a < b);
        if (pick_max) begin
            y = a_lt_b ? b : a;
        end else begin
            y = a_lt_b ? a : b;
        end
    end

endmodule

// File: rtl/randomlogic_window_acc.sv
// Window accumulator: sums WINDOW qualified samples and tracks min/max,
// presenting each completed window through a one-entry valid/ready register.
//
// Handshake: a result transfers on any clk edge where ResultValid and
// ResultReady are both 1; Sum/Min/Max hold still while ResultValid=1 and
// ResultReady=0. The input side has no backpressure, so a window that
// completes while the register is full and not being accepted is dropped
// and recorded in the sticky Overrun flag.
module randomlogic_window_acc
    import randomlogic_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int WINDOW = 4,
    localparam int SW    = DW + clog2(WINDOW),
    localparam int CW    = clog2(WINDOW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] In,
    input  logic          InValid,
    input  logic          Clear,
    output logic [SW-1:0] Sum,
    output logic [DW-1:0] Min,
    output logic [DW-1:0] Max,
    output logic          ResultValid,
    input  logic          ResultReady,
    output logic          Overrun
);

    logic [CW-1:0] cnt;
    logic [SW-1:0] acc_sum;
    logic [DW-1:0] acc_min;
    logic [DW-1:0] acc_max;

    logic [SW-1:0] sample_ext;
    logic [DW-1:0] cmp_min;
    logic [DW-1:0] cmp_max;
    logic [SW-1:0] win_sum;
    logic [DW-1:0] win_min;
    logic [DW-1:0] win_max;

    logic          take;
    logic          first_slot;
    logic          last_slot;
    logic          complete;
    logic          accept;
    logic          load;
    logic          drop;

    randomlogic_minmax #(.DW(DW)) u_min (
        .pick_max (1'b0),
        .a        (acc_min),
        .b        (In),
        .y        (cmp_min)
    );

    randomlogic_minmax #(.DW(DW)) u_max (
        .pick_max (1'b1),
        .a        (acc_max),
        .b        (In),
        .y        (cmp_max)
    );

    // Window-so-far including the current sample; the first slot seeds the
    // window, so the completing sample reaches the result register directly.
    always_comb begin
        sample_ext = {{(SW-DW){1'b0}}, In};
        first_slot = (cnt == '0);
        last_slot  = (cnt == CW'(WINDOW - 1));
        win_sum    = first_slot ? sample_ext : (acc_sum + sample_ext);
        win_min    = first_slot ? In : cmp_min;
        win_max    = first_slot ? In : cmp_max;
    end

    always_comb begin
        take     = InValid && !Clear;
        complete = take && last_slot;
        accept   = ResultValid && ResultReady;
        load     = complete && (!ResultValid || ResultReady);
        drop     = complete && ResultValid && !ResultReady;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc_sum <= '0;
            acc_min <= '1;
            acc_max <= '0;
        end else begin
            if (Clear) begin
                cnt <= '0;
            end else if (InValid) begin
                cnt <= last_slot ? '0 : (cnt + CW'(1));
            end
            if (take) begin
                acc_sum <= win_sum;
                acc_min <= win_min;
                acc_max <= win_max;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum         <= '0;
            Min         <= '0;
            Max         <= '0;
            ResultValid <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            if (load) begin
                Sum         <= win_sum;
                Min         <= win_min;
                Max         <= win_max;
                ResultValid <= 1'b1;
            end else if (accept) begin
                ResultValid <= 1'b0;
            end
            if (drop) begin
                Overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_randomlogic_window_acc.sv
// Directed bench for randomlogic_window_acc with WINDOW=4, DW=8: hand-computed
// window results, hold/overrun, accept-and-reload and Clear behaviour.
module tb_randomlogic_window_acc;

    localparam int DW     = 8;
    localparam int WINDOW = 4;
    localparam int SW     = 10;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          clear;
    logic [SW-1:0] sum;
    logic [DW-1:0] min_v;
    logic [DW-1:0] max_v;
    logic          result_valid;
    logic          result_ready;
    logic          overrun;

    int total;
    int bad;

    randomlogic_window_acc #(.DW(DW), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .rst         (rst),
        .In          (in_data),
        .InValid     (in_valid),
        .Clear       (clear),
        .Sum         (sum),
        .Min         (min_v),
        .Max         (max_v),
        .ResultValid (result_valid),
        .ResultReady (result_ready),
        .Overrun     (overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rv, input int s, input int mn,
                           input int mx, input logic ov);
        chk({tag, ".valid"},   32'(result_valid), 32'(rv));
        chk({tag, ".sum"},     32'(sum),          32'(s));
        chk({tag, ".min"},     32'(min_v),        32'(mn));
        chk({tag, ".max"},     32'(max_v),        32'(mx));
        chk({tag, ".overrun"}, 32'(overrun),      32'(ov));
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        in_data      = 8'd200;
        in_valid     = 1'b1;
        clear        = 1'b0;
        result_ready = 1'b0;

        // reset dominates a valid sample stream
        tick();
        chk_out("reset1", 1'b0, 0, 0, 0, 1'b0);
        tick();
        chk_out("reset2", 1'b0, 0, 0, 0, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // basic window, ready high
        result_ready = 1'b1;
        put(8'd123);
        put(8'd32);
        put(8'd19);
        chk("basic.pre_valid", 32'(result_valid), 32'd0);
        put(8'd7);
        chk_out("basic", 1'b1, 181, 7, 123, 1'b0);
        idle();
        chk("basic.drain", 32'(result_valid), 32'd0);

        // gapped samples
        put(8'd13);
        idle();
        put(8'd42);
        idle();
        idle();
        put(8'd79);
        chk("gap.pre_valid", 32'(result_valid), 32'd0);
        put(8'd6);
        chk_out("gap", 1'b1, 140, 6, 79, 1'b0);
        idle();
        chk("gap.drain", 32'(result_valid), 32'd0);

        // hold then overrun
        result_ready = 1'b0;
        put(8'd1);
        put(8'd2);
        put(8'd3);
        put(8'd4);
        chk_out("hold1", 1'b1, 10, 1, 4, 1'b0);
        put(8'd10);
        put(8'd10);
        put(8'd10);
        chk_out("hold2", 1'b1, 10, 1, 4, 1'b0);
        put(8'd10);
        chk_out("overrun", 1'b1, 10, 1, 4, 1'b1);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        chk("overrun.sticky_clear", 32'(overrun), 32'd1);
        result_ready = 1'b1;
        idle();
        result_ready = 1'b0;
        chk("overrun.accept", 32'(result_valid), 32'd0);
        chk("overrun.sticky", 32'(overrun), 32'd1);
        do_reset();
        chk_out("rereset", 1'b0, 0, 0, 0, 1'b0);

        // accept and reload on the same edge
        put(8'd1);
        put(8'd2);
        put(8'd3);
        put(8'd4);
        chk_out("reload.held", 1'b1, 10, 1, 4, 1'b0);
        put(8'd255);
        put(8'd255);
        put(8'd255);
        result_ready = 1'b1;
        put(8'd255);
        result_ready = 1'b0;
        chk_out("reload", 1'b1, 1020, 255, 255, 1'b0);
        idle();
        chk_out("reload.stable", 1'b1, 1020, 255, 255, 1'b0);
        result_ready = 1'b1;
        idle();
        chk("reload.accept", 32'(result_valid), 32'd0);

        // Clear with a valid sample mid-window
        put(8'd5);
        put(8'd6);
        clear = 1'b1;
        put(8'd99);
        clear = 1'b0;
        put(8'd1);
        put(8'd2);
        put(8'd3);
        chk("clear.pre_valid", 32'(result_valid), 32'd0);
        put(8'd4);
        chk_out("clear", 1'b1, 10, 1, 4, 1'b0);
        idle();
        chk("clear.drain", 32'(result_valid), 32'd0);

        // Clear on the completing cycle yields no result
        put(8'd1);
        put(8'd1);
        put(8'd1);
        clear = 1'b1;
        put(8'd50);
        clear = 1'b0;
        chk("clear_last.none", 32'(result_valid), 32'd0);
        put(8'd2);
        put(8'd2);
        put(8'd2);
        put(8'd2);
        chk_out("clear_last.next", 1'b1, 8, 2, 2, 1'b0);

        // back-to-back windows, no gap cycle, ready tied high
        put(8'd9);
        chk("b2b.accept", 32'(result_valid), 32'd0);
        put(8'd200);
        put(8'd0);
        put(8'd100);
        chk_out("b2b.w1", 1'b1, 309, 0, 200, 1'b0);
        put(8'd17);
        put(8'd18);
        put(8'd19);
        put(8'd20);
        chk_out("b2b.w2", 1'b1, 74, 17, 20, 1'b0);
        idle();
        chk("b2b.drain", 32'(result_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
